spi_reg_writer: RTL

- SPI controller (initiator) that drives the same 3-wire, write-only, mode-0 SPI bus our spi_peripheral receives on.
- Takes a valid/ready register-write request (7-bit address, 8-bit data) and serialises it as one 16-bit frame.
- Used on-chip for self-configuration and by the test harness to program en_reg_out_*, en_reg_pwm_* and pwm_duty_cycle.
- Register map: 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle.

---
 rtl/spi_reg_writer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_writer.sv
// rtl/spi_reg_writer.sv - 3-wire write-only mode-0 SPI initiator for 16-bit register-write frames
//
// Takes one valid/ready register-write request and shifts it out MSB first
// as the frame {1'b1, addr[6:0], data[7:0]}.
// Frame sequence: LEAD (ncs low), 16 x (sclk high, sclk low), GAP (ncs high).
// Each of these phases lasts CLK_DIV clock cycles.
//
// Parameters:
//   CLK_DIV    clk cycles per SCLK half-period, 4..255
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  write request present
//   req_ready  idle and able to accept a request
//   req_addr   register address (7 bits)
//   req_data   register data (8 bits)
//   spi_sclk   serial clock, idles low
//   spi_copi   serial data, MSB first
//   spi_ncs    chip select, active low
//   busy       frame in progress
//   done       one-cycle pulse at end of frame
//   req_err    one-cycle pulse when a request is rejected
//
// Optional feature macro: SPI_WR_ADDR_CHECK_EN.
// When it is defined, requests with an address above 0x04 are consumed
// without sending a frame, and req_err pulses.
// When it is undefined, every address is sent and req_err is tied to 0.

module spi_reg_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       spi_sclk,
  output logic       spi_copi,
  output logic       spi_ncs,
  output logic       busy,
  output logic       done,
  output logic       req_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_div, w_div_nxt;
  logic [3:0]  r_bit, w_bit_nxt;
  logic [15:0] r_frame, w_frame_nxt;
  logic        r_sclk, w_sclk_nxt;
  logic        r_copi, w_copi_nxt;
  logic        r_ncs, w_ncs_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_err, w_err_nxt;
  logic        r_ready, w_ready_nxt;

  logic w_phase_end;
  logic w_accept;
  logic w_addr_bad;

  assign w_phase_end = (r_div == DIV_LAST);
  assign w_accept    = req_valid && r_ready;

`ifdef SPI_WR_ADDR_CHECK_EN
  assign w_addr_bad = (req_addr > 7'h04);
`else
  assign w_addr_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_frame <= '0;
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_ncs   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_frame <= w_frame_nxt;
      r_sclk  <= w_sclk_nxt;
      r_copi  <= w_copi_nxt;
      r_ncs   <= w_ncs_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Next-state logic also computes the next value of every output.
  // All outputs then come straight from flops, so the SPI pins cannot glitch.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_phase_end ? 8'd0 : r_div + 8'd1;
    w_bit_nxt   = r_bit;
    w_frame_nxt = r_frame;
    w_sclk_nxt  = r_sclk;
    w_copi_nxt  = r_copi;
    w_ncs_nxt   = r_ncs;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_ready_nxt = r_ready;

    case (r_state)
      ST_IDLE: begin
        w_div_nxt   = 8'd0;
        w_ready_nxt = 1'b1;
        if (w_accept) begin
          w_ready_nxt = 1'b0;
          if (w_addr_bad) begin
            // Consume the request without sending anything.
            // req_ready drops for one cycle, as it would for a real accept.
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_LEAD;
            w_frame_nxt = {1'b1, req_addr, req_data};
            w_ncs_nxt   = 1'b0;
            w_sclk_nxt  = 1'b0;
            w_copi_nxt  = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end
      end

      ST_LEAD: begin
        if (w_phase_end) begin
          w_state_nxt = ST_SHIFT;
          w_sclk_nxt  = 1'b1;
          w_bit_nxt   = 4'd15;
        end
      end

      ST_SHIFT: begin
        if (w_phase_end) begin
          if (r_sclk) begin
            // Falling edge: present the next bit so it is settled a full
            // half-period before the receiver's rising-edge sample.
            w_sclk_nxt = 1'b0;
            if (r_bit != 4'd0) begin
              w_copi_nxt = r_frame[r_bit - 4'd1];
            end
          end else if (r_bit == 4'd0) begin
            w_state_nxt = ST_GAP;
            w_ncs_nxt   = 1'b1;
            w_copi_nxt  = 1'b0;
          end else begin
            w_bit_nxt  = r_bit - 4'd1;
            w_sclk_nxt = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (w_phase_end) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req_ready = r_ready;
  assign spi_sclk  = r_sclk;
  assign spi_copi  = r_copi;
  assign spi_ncs   = r_ncs;
  assign busy      = r_busy;
  assign done      = r_done;
  assign req_err   = r_err;

endmodule
